bitbakery_serial_rx: RTL



---
 rtl/bitbakery_serial_pkg.sv | 31 +++
 rtl/uart_rx_8n1.sv | 110 +++++++++++
 rtl/bitbakery_serial_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bitbakery_serial_pkg.sv
// Shared definitions for the BitBakery telemetry link: tags, map framing and
// the default bit period used by both the transmitter and this receiver.
package bitbakery_serial_pkg;

  localparam logic [1:0] TAG_STATUS = 2'b00;
  localparam logic [1:0] TAG_JOGADA = 2'b01;
  localparam logic [1:0] TAG_EXTRA  = 2'b10;
  localparam logic [1:0] TAG_MAP    = 2'b11;

  localparam logic [7:0]  MAP_HEADER = 8'hC0;
  localparam int unsigned MAP_BYTES  = 8;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [3:0] {
    DEC_TAG = 4'h0,
    DEC_MAP = 4'h1
  } dec_state_t;

  function automatic logic [1:0] tag_of(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 byte receiver: two-flop line synchroniser, start-bit validation at
// mid-bit, LSB-first data capture and stop-bit check.
module uart_rx_8n1
  import bitbakery_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] dado_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       start_o,
  output logic       idle_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            wait_high_q;
  logic [7:0]      dado_q;
  logic            byte_valid_q, byte_err_q;
  logic            fall;

  assign fall    = prev_q & ~sync2_q;
  assign start_o = (state_q == RX_IDLE) && fall;
  assign idle_o  = (state_q == RX_IDLE);

  assign dado_o       = dado_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_err_o   = byte_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Line idles high, so the synchroniser resets high to avoid a false start
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      wait_high_q  <= 1'b0;
      dado_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (fall) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (wait_high_q) begin
            // A broken frame leaves the line low; hold off until it recovers
            if (sync2_q) begin
              wait_high_q <= 1'b0;
              state_q     <= RX_IDLE;
            end
          end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (sync2_q) begin
              dado_q       <= shift_q;
              byte_valid_q <= 1'b1;
              state_q      <= RX_IDLE;
            end else begin
              byte_err_q  <= 1'b1;
              wait_high_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bitbakery_serial_rx.sv
// Telemetry receiver top: decodes tagged status bytes and 8-byte obstacle-map
// bursts from the console transmitter into registered console state.
module bitbakery_serial_rx
  import bitbakery_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [1:0]  minigame,
  output logic [3:0]  estado,
  output logic [6:0]  jogada,
  output logic        dificuldade,
  output logic [3:0]  player_position,
  output logic [63:0] map_obstacles,
  output logic        atualizado,
  output logic        mapa_valido,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
);

  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);

  logic [7:0] dado;
  logic       byte_valid, byte_err, rx_start, rx_idle;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (entrada_serial),
    .dado_o      (dado),
    .byte_valid_o(byte_valid),
    .byte_err_o  (byte_err),
    .start_o     (rx_start),
    .idle_o      (rx_idle)
  );

  dec_state_t  dec_q;
  logic [2:0]  byte_cnt_q;
  logic [63:0] shadow_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]  minigame_q;
  logic [3:0]  estado_q;
  logic [6:0]  jogada_q;
  logic        dificuldade_q;
  logic [3:0]  player_position_q;
  logic [63:0] map_q;
  logic        atualizado_q, mapa_valido_q, erro_quadro_q;

  logic [63:0] shadow_d;
  logic        timeout_hit;

  // Byte k of the burst lands at bits [63-8k -: 8]; ~k*8 is the low index
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[{~byte_cnt_q, 3'b000} +: 8] = dado;
  end

  assign timeout_hit = (dec_q == DEC_MAP) && (tmo_q == TW'(TMO_LIMIT));

  // Idle-gap watchdog for map bursts; restarts on every start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (dec_q != DEC_MAP || rx_start) begin
      tmo_q <= '0;
    end else if (rx_idle && !timeout_hit) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q             <= DEC_TAG;
      byte_cnt_q        <= '0;
      shadow_q          <= '0;
      minigame_q        <= 2'b11;
      estado_q          <= '0;
      jogada_q          <= '0;
      dificuldade_q     <= 1'b0;
      player_position_q <= '0;
      map_q             <= '0;
      atualizado_q      <= 1'b0;
      mapa_valido_q     <= 1'b0;
      erro_quadro_q     <= 1'b0;
    end else begin
      atualizado_q  <= 1'b0;
      mapa_valido_q <= 1'b0;
      erro_quadro_q <= 1'b0;
      case (dec_q)
        DEC_TAG: begin
          if (byte_err) begin
            erro_quadro_q <= 1'b1;
          end else if (byte_valid) begin
            case (tag_of(dado))
              TAG_STATUS: begin
                if ({minigame_q, estado_q} != dado[5:0]) begin
                  {minigame_q, estado_q} <= dado[5:0];
                  atualizado_q <= 1'b1;
                end
              end
              TAG_JOGADA: begin
                if (jogada_q[5:0] != dado[5:0]) begin
                  jogada_q[5:0] <= dado[5:0];
                  atualizado_q  <= 1'b1;
                end
              end
              TAG_EXTRA: begin
                if ({jogada_q[6], dificuldade_q, player_position_q} != dado[5:0]) begin
                  {jogada_q[6], dificuldade_q, player_position_q} <= dado[5:0];
                  atualizado_q <= 1'b1;
                end
              end
              default: begin
                if (dado == MAP_HEADER) begin
                  dec_q      <= DEC_MAP;
                  byte_cnt_q <= '0;
                  shadow_q   <= '0;
                end
              end
            endcase
          end
        end
        DEC_MAP: begin
          if (byte_err || timeout_hit) begin
            erro_quadro_q <= 1'b1;
            dec_q         <= DEC_TAG;
          end else if (byte_valid) begin
            if (byte_cnt_q == 3'(MAP_BYTES - 1)) begin
              map_q         <= shadow_d;
              mapa_valido_q <= 1'b1;
              dec_q         <= DEC_TAG;
            end else begin
              shadow_q   <= shadow_d;
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        default: dec_q <= DEC_TAG;
      endcase
    end
  end

  assign minigame        = minigame_q;
  assign estado          = estado_q;
  assign jogada          = jogada_q;
  assign dificuldade     = dificuldade_q;
  assign player_position = player_position_q;
  assign map_obstacles   = map_q;
  assign atualizado      = atualizado_q;
  assign mapa_valido     = mapa_valido_q;
  assign erro_quadro     = erro_quadro_q;
  assign db_estado       = dec_q;

endmodule
